// File: rtl/toggle_divider_bank_if.sv
// ----------------------------------------------------------------------------
// toggle_divider_bank_if
//   Bundles the control inputs and toggle outputs of toggle_divider_bank.
//   Clock and reset are not part of the bundle.
//
//   tog_en    [Width]        per-channel count/toggle enable
//   clr       [Width]        per-channel synchronous clear/re-arm
//   one_shot  [Width]        per-channel mode, 1 = stop after first toggle
//   div_val   [Count_Width]  shared divide value, period = div_val+1 enables
//   Q         [Width]        registered toggle outputs
//   done      [Width]        channel has completed its one-shot toggle
//   tog_pulse [Width]        one-cycle strobe aligned with a new Q value
//
//   master: drives controls, observes outputs (stimulus side)
//   slave : the divider bank itself
// ----------------------------------------------------------------------------
interface toggle_divider_bank_if #(
    parameter int Width       = 1,
    parameter int Count_Width = 8
);
    logic [Width-1:0]       tog_en;
    logic [Width-1:0]       clr;
    logic [Width-1:0]       one_shot;
    logic [Count_Width-1:0] div_val;
    logic [Width-1:0]       Q;
    logic [Width-1:0]       done;
    logic [Width-1:0]       tog_pulse;

    modport master (
        output tog_en, clr, one_shot, div_val,
        input  Q, done, tog_pulse
    );

    modport slave (
        input  tog_en, clr, one_shot, div_val,
        output Q, done, tog_pulse
    );
endinterface

// File: rtl/toggle_divider_bank.sv
// ----------------------------------------------------------------------------
// toggle_divider_bank
//   Bank of Width independent toggle channels. Each channel flips its Q output
//   once per (div_val+1) enabled cycles; in one-shot mode it stops after the
//   first toggle until cleared. With div_val=0 and no one-shot a channel is a
//   plain enabled toggle flip-flop.
//
//   Ports:
//     clk     core clock, all state on rising edge
//     ares_L  asynchronous reset, active low
//     bus     toggle_divider_bank_if.slave (tog_en, clr, one_shot, div_val in;
//             Q, done, tog_pulse out)
//
//   Parameters:
//     Width        number of channels
//     Count_Width  width of per-channel counter and div_val
//     Init_Value   value of Q after reset and on clr
//
//   Configuration macro: TOGGLE_BANK_PULSE_EN
//     defined   : tog_pulse[i] is a registered strobe high for the cycle in
//                 which Q[i] shows a counted toggle (never for clr changes)
//     undefined : tog_pulse is tied low and no pulse flops exist
// ----------------------------------------------------------------------------
module toggle_divider_bank #(
    parameter int               Width       = 1,
    parameter int               Count_Width = 8,
    parameter logic [Width-1:0] Init_Value  = '0
) (
    input  logic                       clk,
    input  logic                       ares_L,
    toggle_divider_bank_if.slave       bus
);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t                 state [Width];
    logic [Count_Width-1:0] cnt   [Width];
    logic [Width-1:0]       q_r;
    logic [Width-1:0]       done_r;
    logic [Width-1:0]       hit;

    // A channel toggles when enabled, running, not being cleared, and its
    // count has reached div_val. The >= lets a lowered div_val fire at once.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            hit[i] = bus.tog_en[i] && !bus.clr[i] && (state[i] == RUN) &&
                     (cnt[i] >= bus.div_val);
        end
    end

    always_ff @(posedge clk or negedge ares_L) begin
        if (!ares_L) begin
            for (int unsigned i = 0; i < Width; i++) begin
                cnt[i]   <= '0;
                state[i] <= RUN;
            end
            q_r    <= Init_Value;
            done_r <= '0;
        end else begin
            for (int unsigned i = 0; i < Width; i++) begin
                if (bus.clr[i]) begin
                    cnt[i]    <= '0;
                    q_r[i]    <= Init_Value[i];
                    state[i]  <= RUN;
                    done_r[i] <= 1'b0;
                end else if (state[i] == DONE) begin
                    cnt[i] <= '0;
                end else if (bus.tog_en[i]) begin
                    if (hit[i]) begin
                        q_r[i] <= ~q_r[i];
                        cnt[i] <= '0;
                        if (bus.one_shot[i]) begin
                            state[i]  <= DONE;
                            done_r[i] <= 1'b1;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + Count_Width'(1);
                    end
                end
            end
        end
    end

    assign bus.Q    = q_r;
    assign bus.done = done_r;

`ifdef TOGGLE_BANK_PULSE_EN
    logic [Width-1:0] pulse_r;

    always_ff @(posedge clk or negedge ares_L) begin
        if (!ares_L) begin
            pulse_r <= '0;
        end else begin
            pulse_r <= hit;
        end
    end

    assign bus.tog_pulse = pulse_r;
`else
    assign bus.tog_pulse = '0;
`endif

endmodule

// File: tb/tb_toggle_divider_bank.sv
// ----------------------------------------------------------------------------
// tb_toggle_divider_bank
//   Directed vectors for a 4-channel bank with Init_Value = 4'b0101.
//   Each vector carries hand-computed Q/done/tog_pulse expected after the
//   edge that samples it; a monitor pops and compares one entry per edge.
// ----------------------------------------------------------------------------
module tb_toggle_divider_bank;

    localparam int         W    = 4;
    localparam int         CW   = 8;
    localparam logic [3:0] INIT = 4'b0101;

    typedef struct {
        logic [3:0] q;
        logic [3:0] d;
        logic [3:0] p;
        string      name;
    } exp_t;

    logic clk;
    logic ares_L;
    exp_t exp_q [$];
    int   n_vec  = 0;
    int   n_fail = 0;
    string grp = "init";

    toggle_divider_bank_if #(.Width(W), .Count_Width(CW)) bus ();

    toggle_divider_bank #(
        .Width      (W),
        .Count_Width(CW),
        .Init_Value (INIT)
    ) dut (
        .clk   (clk),
        .ares_L(ares_L),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pexp(input logic [3:0] p);
`ifdef TOGGLE_BANK_PULSE_EN
        return p;
`else
        return 4'b0000 & p;
`endif
    endfunction

    task automatic check_now(input string name, input logic [3:0] q,
                             input logic [3:0] d, input logic [3:0] p);
        n_vec++;
        if (bus.Q !== q || bus.done !== d || bus.tog_pulse !== pexp(p)) begin
            n_fail++;
            $display("FAIL %s: got Q=%b done=%b pulse=%b, want Q=%b done=%b pulse=%b",
                     name, bus.Q, bus.done, bus.tog_pulse, q, d, pexp(p));
        end
    endtask

    // Monitor: one comparison per rising edge for each queued vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_now(e.name, e.q, e.d, e.p);
            end
        end
    end

    task automatic vec(input logic [3:0] en, input logic [3:0] cl,
                       input logic [3:0] os, input logic [7:0] dv,
                       input logic [3:0] q, input logic [3:0] d,
                       input logic [3:0] p);
        exp_t e;
        @(negedge clk);
        bus.tog_en   = en;
        bus.clr      = cl;
        bus.one_shot = os;
        bus.div_val  = dv;
        e.q = q; e.d = d; e.p = p; e.name = grp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int unsigned budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d vectors left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus.tog_en   = '0;
        bus.clr      = '0;
        bus.one_shot = '0;
        bus.div_val  = '0;
        ares_L       = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_now("reset_state", INIT, 4'b0000, 4'b0000);
        @(negedge clk);
        ares_L = 1'b1;

        // div_val=0: every bit toggles each enabled cycle, back to Init after 6
        grp = "div0_all";
        for (int k = 0; k < 6; k++)
            vec(4'hF, 4'h0, 4'h0, 8'd0, (k % 2 == 0) ? 4'b1010 : 4'b0101, 4'h0, 4'hF);

        // div_val=3, ch0 enabled on alternate cycles: toggle on 4th enable
        grp = "div3_alt";
        for (int k = 0; k < 6; k++)
            vec((k % 2 == 0) ? 4'b0001 : 4'b0000, 4'h0, 4'h0, 8'd3, 4'b0101, 4'h0, 4'h0);
        vec(4'b0001, 4'h0, 4'h0, 8'd3, 4'b0100, 4'h0, 4'b0001);
        vec(4'b0000, 4'h0, 4'h0, 8'd3, 4'b0100, 4'h0, 4'h0);

        // one-shot on ch1, div_val=2
        grp = "oneshot";
        vec(4'b0010, 4'h0, 4'b0010, 8'd2, 4'b0100, 4'h0, 4'h0);
        vec(4'b0010, 4'h0, 4'b0010, 8'd2, 4'b0100, 4'h0, 4'h0);
        vec(4'b0010, 4'h0, 4'b0010, 8'd2, 4'b0110, 4'b0010, 4'b0010);
        grp = "done_hold";
        for (int k = 0; k < 10; k++)
            vec(4'b0010, 4'h0, 4'h0, 8'd2, 4'b0110, 4'b0010, 4'h0);
        grp = "rearm";
        vec(4'b0010, 4'b0010, 4'b0010, 8'd2, 4'b0100, 4'h0, 4'h0);
        vec(4'b0010, 4'h0, 4'h0, 8'd2, 4'b0100, 4'h0, 4'h0);
        vec(4'b0010, 4'h0, 4'h0, 8'd2, 4'b0100, 4'h0, 4'h0);
        vec(4'b0010, 4'h0, 4'h0, 8'd2, 4'b0110, 4'h0, 4'b0010);

        // ch2: clr beats a qualifying toggle, then counting restarts from 0
        grp = "clr_prio";
        vec(4'b0100, 4'h0, 4'h0, 8'd2, 4'b0110, 4'h0, 4'h0);
        vec(4'b0100, 4'h0, 4'h0, 8'd2, 4'b0110, 4'h0, 4'h0);
        vec(4'b0100, 4'h0, 4'h0, 8'd2, 4'b0010, 4'h0, 4'b0100);
        vec(4'b0100, 4'h0, 4'h0, 8'd2, 4'b0010, 4'h0, 4'h0);
        vec(4'b0100, 4'h0, 4'h0, 8'd2, 4'b0010, 4'h0, 4'h0);
        vec(4'b0100, 4'b0100, 4'h0, 8'd2, 4'b0110, 4'h0, 4'h0);
        vec(4'b0100, 4'h0, 4'h0, 8'd2, 4'b0110, 4'h0, 4'h0);
        vec(4'b0100, 4'h0, 4'h0, 8'd2, 4'b0110, 4'h0, 4'h0);
        vec(4'b0100, 4'h0, 4'h0, 8'd2, 4'b0010, 4'h0, 4'b0100);
        vec(4'b0000, 4'h0, 4'h0, 8'd2, 4'b0010, 4'h0, 4'h0);

        // ch0: count to 5 under div_val=10, then lower div_val to 2
        grp = "div_lower";
        for (int k = 0; k < 5; k++)
            vec(4'b0001, 4'h0, 4'h0, 8'd10, 4'b0010, 4'h0, 4'h0);
        vec(4'b0001, 4'h0, 4'h0, 8'd2, 4'b0011, 4'h0, 4'b0001);
        vec(4'b0001, 4'h0, 4'h0, 8'd2, 4'b0011, 4'h0, 4'h0);

        // ch3: maximum divide, 256 enables per toggle, counter restarts
        grp = "div_max";
        for (int k = 0; k < 255; k++)
            vec(4'b1000, 4'h0, 4'h0, 8'd255, 4'b0011, 4'h0, 4'h0);
        vec(4'b1000, 4'h0, 4'h0, 8'd255, 4'b1011, 4'h0, 4'b1000);
        vec(4'b1000, 4'h0, 4'h0, 8'd255, 4'b1011, 4'h0, 4'h0);

        // ch3 one-shot then DONE holds against further enables
        grp = "os_div0";
        vec(4'b1000, 4'h0, 4'b1000, 8'd0, 4'b0011, 4'b1000, 4'b1000);
        vec(4'b1000, 4'h0, 4'h0, 8'd0, 4'b0011, 4'b1000, 4'h0);

        @(negedge clk);
        bus.tog_en   = '0;
        bus.one_shot = '0;
        drain();

        // asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        ares_L = 1'b0;
        #1;
        check_now("async_reset", INIT, 4'b0000, 4'b0000);
        @(negedge clk);
        ares_L = 1'b1;
        grp = "post_reset";
        vec(4'b0000, 4'h0, 4'h0, 8'd0, INIT, 4'h0, 4'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
